// File: rtl/fir_mac_pipe.sv
// fir_mac_pipe: pipelined multiplier for a folded FIR tap engine.
// Operands are sign- or zero-extended according to their signedness, and the
// exact product is mapped to DOUT_WIDTH. The product travels NUM_STAGE
// registers with valid/first/last flags. An optional accumulator produces one
// sum per framed sequence of samples.
module fir_mac_pipe #(
    parameter int DIN0_WIDTH  = 16,
    parameter int DIN1_WIDTH  = 8,
    parameter int DOUT_WIDTH  = 24,
    parameter int DIN0_SIGNED = 1,
    parameter int DIN1_SIGNED = 0,
    parameter int NUM_STAGE   = 2,
    parameter int ACC_MODE    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  out_valid,
    output logic [DOUT_WIDTH-1:0] dout
);

    // Multiplier width: both operands plus one extension bit each. This holds
    // the exact product for every signedness combination.
    localparam int FW   = DIN0_WIDTH + DIN1_WIDTH + 2;
    localparam int LAST = NUM_STAGE - 1;

    logic                  sign0;
    logic                  sign1;
    logic signed [FW-1:0]  op0;
    logic signed [FW-1:0]  op1;
    logic signed [FW-1:0]  full;
    logic [DOUT_WIDTH-1:0] p_map;

    assign sign0 = (DIN0_SIGNED != 0) ? din0[DIN0_WIDTH-1] : 1'b0;
    assign sign1 = (DIN1_SIGNED != 0) ? din1[DIN1_WIDTH-1] : 1'b0;
    assign op0   = {{(FW - DIN0_WIDTH){sign0}}, din0};
    assign op1   = {{(FW - DIN1_WIDTH){sign1}}, din1};
    assign full  = op0 * op1;

    // The exact product is already sign-correct, so widening it by sign
    // extension also covers the unsigned case, where the top bit is 0.
    generate
        if (DOUT_WIDTH > FW) begin : g_widen
            assign p_map = {{(DOUT_WIDTH - FW){full[FW-1]}}, full};
        end else begin : g_trunc
            logic unused_high;
            assign p_map       = full[DOUT_WIDTH-1:0];
            assign unused_high = ^{1'b0, full};
        end
    endgenerate

    logic [DOUT_WIDTH-1:0] stage_p [NUM_STAGE];
    logic [NUM_STAGE-1:0]  stage_v;
    logic [NUM_STAGE-1:0]  stage_f;
    logic [NUM_STAGE-1:0]  stage_l;

    // Product/flag pipeline: stage 0 captures the product, later stages retime it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_STAGE; i++) begin
                stage_p[i] <= '0;
            end
            stage_v <= '0;
            stage_f <= '0;
            stage_l <= '0;
        end else if (ce) begin
            stage_p[0] <= p_map;
            stage_v[0] <= in_valid;
            stage_f[0] <= in_valid & in_first;
            stage_l[0] <= in_valid & in_last;
            for (int i = 1; i < NUM_STAGE; i++) begin
                stage_p[i] <= stage_p[i-1];
                stage_v[i] <= stage_v[i-1];
                stage_f[i] <= stage_f[i-1];
                stage_l[i] <= stage_l[i-1];
            end
        end
    end

    generate
        if (ACC_MODE == 0) begin : g_mul
            logic unused_flags;
            assign unused_flags = ^{1'b0, stage_f, stage_l};
            assign dout         = stage_p[LAST];
            assign out_valid    = stage_v[LAST];
        end else begin : g_acc
            logic [DOUT_WIDTH-1:0] acc;
            logic [DOUT_WIDTH-1:0] acc_next;
            logic [DOUT_WIDTH-1:0] dout_r;
            logic                  out_valid_r;

            // Next accumulator value: restart on first, otherwise wrap-add.
            always_comb begin
                acc_next = acc;
                if (stage_f[LAST]) begin
                    acc_next = stage_p[LAST];
                end else begin
                    acc_next = acc + stage_p[LAST];
                end
            end

            // Accumulator and result register, updated only by valid products.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    acc         <= '0;
                    dout_r      <= '0;
                    out_valid_r <= 1'b0;
                end else if (ce) begin
                    if (stage_v[LAST]) begin
                        acc <= acc_next;
                    end
                    if (stage_v[LAST] && stage_l[LAST]) begin
                        dout_r <= acc_next;
                    end
                    out_valid_r <= stage_v[LAST] & stage_l[LAST];
                end
            end

            assign dout      = dout_r;
            assign out_valid = out_valid_r;
        end
    endgenerate

endmodule

// File: doc/fir_mac_pipe.md
# fir_mac_pipe

Parametrised, pipelined multiplier for the transposed/folded FIR datapath. It supports per-operand signedness, clock-enable stalls and a valid pipeline. An optional accumulate mode lets one folded tap engine sum a sequence of coefficient×sample products and emit a single result per output sample. It sits between the coefficient/delay-line fetch logic and the output register of the folded filter.

## Interface
- DIN0_WIDTH, 16: width of the data operand.
- DIN1_WIDTH, 8: width of the coefficient operand.
- DOUT_WIDTH, 24: width of the result and of the accumulator.
- DIN0_SIGNED, 1: 1 means din0 is two's complement; 0 means unsigned.
- DIN1_SIGNED, 0: 1 means din1 is two's complement; 0 means unsigned (zero-extended).
- NUM_STAGE, 2: number of product pipeline registers. Legal range is 1..4.
- ACC_MODE, 0: 0 selects plain multiply; 1 selects multiply-accumulate.

Ports:
- clk, in, 1: clock, rising edge.
- reset, in, 1: asynchronous, active-high reset.
- ce, in, 1: clock enable. When low, every register holds its value.
- in_valid, in, 1: din0/din1 carry a sample this cycle.
- in_first, in, 1: ACC_MODE only. This sample starts a new sum.
- in_last, in, 1: ACC_MODE only. This sample ends the sum.
- din0, in, DIN0_WIDTH: data operand.
- din1, in, DIN1_WIDTH: coefficient operand.
- out_valid, out, 1: dout is valid this cycle.
- dout, out, DOUT_WIDTH: product (ACC_MODE=0) or finished sum (ACC_MODE=1).

## Operation
- A sample is accepted when ce=1 and in_valid=1.
- With ce=1 and in_valid=0, a bubble enters the pipeline. Bubbles never touch the accumulator and never raise out_valid.
- Operand extension: each operand is extended by one bit, with sign or zero fill according to its *_SIGNED parameter.
- The full product P is DIN0_WIDTH+DIN1_WIDTH bits. It is two's complement if either operand is signed.
- Mapping P to DOUT_WIDTH:
  - If DOUT_WIDTH is smaller, keep the low bits.
  - If DOUT_WIDTH is larger, extend P (sign-extend if signed, otherwise zero-extend).
- Pipeline: P and the flags travel through NUM_STAGE registers together with a valid bit. Stage 1 registers the operands (or the product); the remaining stages are retiming stages.
- ACC_MODE=0: dout equals the final stage product; out_valid equals the final stage valid bit.
- ACC_MODE=1: the accumulator ACC (DOUT_WIDTH bits) is updated only when a valid product reaches the final stage.
  - If its first flag is set, ACC is loaded with P.
  - Otherwise ACC becomes ACC+P, wrapping modulo 2^DOUT_WIDTH. There is no saturation.
- Result register (ACC_MODE=1): when the updated sample carries last, the updated ACC value is loaded into dout and out_valid=1 for one ce-qualified cycle. Otherwise out_valid=0 and dout holds its previous value.
- first and last on the same sample: the result is P alone.
- A sample without first after a completed sum keeps accumulating onto the old ACC. Framing is the caller's responsibility.
- In_first/in_last are ignored when ACC_MODE=0.

## Timing
- Reset (asynchronous, takes effect immediately): all pipeline data and valid bits, ACC, dout and out_valid go to 0.
- On reset release, the first sample is accepted on the next rising edge with ce=1.
- Latency, counted in ce-qualified cycles from acceptance:
  - ACC_MODE=0: out_valid/dout appear after NUM_STAGE cycles.
  - ACC_MODE=1: the sum appears NUM_STAGE+1 cycles after the last sample is accepted.
- Throughput is one sample per ce cycle, with no back-pressure.
- ce=0: the whole pipeline, ACC, dout and out_valid are frozen. An out_valid that is high stays high. Stalls insert no extra results and drop none.
- Reset mid-sum: the partial sum and all in-flight samples are discarded.

## Test plan
- Reset: assert reset asynchronously mid-stream with nonzero data in flight. Required response: dout=0x000000, out_valid=0 and ACC=0 immediately; the first post-reset sum excludes all earlier samples.
- ACC_MODE=0, NUM_STAGE=2: din0=0xFFFD (-3), din1=0xC8 (200). Required response: dout=0xFFFDA8 (-600) with out_valid=1 exactly 2 cycles later.
- Extremes, ACC_MODE=0: din0=0x8000, din1=0xFF. Required response: dout=0x808000. With din0=0x7FFF, din1=0xFF, dout=0x7F7F01. Back-to-back samples produce results on consecutive cycles.
- ce stall: stream 6 products with ce low for 3 cycles in the middle. Required response: outputs are frozen during the stall, the order is preserved, and exactly 6 out_valid pulses occur.
- ACC_MODE=1, NUM_STAGE=2: samples (1,10)first, (2,20), bubble, (-3,30), (4,40)last. Required response: a single out_valid with dout=0x000078 (120), 3 cycles after the last sample.
- Wrap and first+last: 3×(0x7FFF,0xFF) with first/last framing gives dout=0x7E7D03. A single sample (5,7) with first and last set gives dout=0x000023.
